// File: rtl/pc_npc_sequencer.sv
// SPARC V8 PC/nPC pair with delayed-branch sequencing, delay-slot annul state
// and a misaligned-JMPL error hold that only a trap can leave.
module pc_npc_sequencer #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic             br_uncond,
  input  logic             br_annul,
  input  logic [WIDTH-1:0] disp,
  input  logic             jmpl_valid,
  input  logic [WIDTH-1:0] jmpl_target,
  input  logic             trap_req,
  input  logic [WIDTH-1:0] trap_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             annul_slot,
  output logic             align_err
);

  localparam int unsigned STATE_W = 2;

  // Bit 0 flags ANNUL and bit 1 flags ERR, so both status outputs are flop bits.
  localparam logic [STATE_W-1:0] RUN   = 2'b00;
  localparam logic [STATE_W-1:0] ANNUL = 2'b01;
  localparam logic [STATE_W-1:0] ERR   = 2'b10;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   npc_q, npc_d;

  // State and address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + STEP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
    end
  end

  // Next-state and next-address selection, highest priority first
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    if (trap_req) begin
      pc_d    = trap_addr;
      npc_d   = trap_addr + STEP;
      state_d = RUN;
    end else if (state_q == ERR) begin
      state_d = ERR;
    end else if (advance) begin
      if (state_q == ANNUL) begin
        pc_d    = npc_q;
        npc_d   = npc_q + STEP;
        state_d = RUN;
      end else if (jmpl_valid) begin
        if (jmpl_target[1:0] != 2'b00) begin
          state_d = ERR;
        end else begin
          pc_d  = npc_q;
          npc_d = jmpl_target;
        end
      end else if (br_valid) begin
        pc_d    = npc_q;
        npc_d   = br_taken ? (pc_q + disp) : (npc_q + STEP);
        // A taken conditional with a=1 still executes its slot; BA,a does not.
        state_d = (br_annul && (br_uncond || !br_taken)) ? ANNUL : RUN;
      end else begin
        pc_d    = npc_q;
        npc_d   = npc_q + STEP;
        state_d = RUN;
      end
    end
  end

  assign pc         = pc_q;
  assign npc        = npc_q;
  assign annul_slot = state_q[0];
  assign align_err  = state_q[1];

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed bench for pc_npc_sequencer: hand-computed pc/npc/status after each step.
module tb_pc_npc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance, br_valid, br_taken, br_uncond, br_annul;
  logic [31:0] disp;
  logic        jmpl_valid;
  logic [31:0] jmpl_target;
  logic        trap_req;
  logic [31:0] trap_addr;
  logic [31:0] pc, npc;
  logic        annul_slot, align_err;

  int checks = 0;
  int errors = 0;

  pc_npc_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .advance(advance),
    .br_valid(br_valid), .br_taken(br_taken), .br_uncond(br_uncond), .br_annul(br_annul),
    .disp(disp), .jmpl_valid(jmpl_valid), .jmpl_target(jmpl_target),
    .trap_req(trap_req), .trap_addr(trap_addr),
    .pc(pc), .npc(npc), .annul_slot(annul_slot), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] enpc,
                           input logic ean, input logic eerr);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".npc"}, npc, enpc);
    chk({tag, ".annul"}, 32'(annul_slot), 32'(ean));
    chk({tag, ".err"}, 32'(align_err), 32'(eerr));
  endtask

  task automatic idle();
    advance = 0; br_valid = 0; br_taken = 0; br_uncond = 0; br_annul = 0;
    disp = '0; jmpl_valid = 0; jmpl_target = '0; trap_req = 0; trap_addr = '0;
  endtask

  // One stepping edge, then sample 1 ns later and return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic trap_to(input logic [31:0] a);
    trap_req = 1; trap_addr = a;
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    chk_state("reset", 32'h0, 32'h4, 0, 0);
    reset = 0;

    // Three sequential advances from reset
    for (int i = 0; i < 3; i++) begin
      advance = 1;
      tick();
    end
    chk_state("seq3", 32'hC, 32'h10, 0, 0);

    // Taken branch backwards, a=0
    trap_to(32'h100);
    chk_state("trap100", 32'h100, 32'h104, 0, 0);
    advance = 1; br_valid = 1; br_taken = 1; disp = 32'hFFFF_FFF0;
    tick();
    chk_state("br_taken", 32'h104, 32'hF0, 0, 0);
    advance = 1;
    tick();
    chk_state("br_target", 32'hF0, 32'hF4, 0, 0);

    // Untaken bne,a annuls the slot; branch inputs in the slot are ignored
    trap_to(32'h200);
    advance = 1; br_valid = 1; br_taken = 0; br_annul = 1;
    tick();
    chk_state("bne_a", 32'h204, 32'h208, 1, 0);
    advance = 1; br_valid = 1; br_taken = 1; disp = 32'h1000; jmpl_valid = 1; jmpl_target = 32'h3;
    tick();
    chk_state("annul_skip", 32'h208, 32'h20C, 0, 0);

    // Taken conditional with a=1 executes its slot
    trap_to(32'h280);
    advance = 1; br_valid = 1; br_taken = 1; br_annul = 1; disp = 32'h20;
    tick();
    chk_state("bcc_a_taken", 32'h284, 32'h2A0, 0, 0);

    // ba,a annuls the slot and still redirects
    trap_to(32'h300);
    advance = 1; br_valid = 1; br_taken = 1; br_uncond = 1; br_annul = 1; disp = 32'h40;
    tick();
    chk_state("ba_a", 32'h304, 32'h340, 1, 0);
    advance = 1;
    tick();
    chk_state("ba_a_next", 32'h340, 32'h344, 0, 0);

    // Aligned JMPL wins over a simultaneous branch
    advance = 1; jmpl_valid = 1; jmpl_target = 32'h1000; br_valid = 1; br_taken = 1; disp = 32'h8;
    tick();
    chk_state("jmpl_ok", 32'h344, 32'h1000, 0, 0);

    // Misaligned JMPL enters ERR and freezes through advances
    advance = 1; jmpl_valid = 1; jmpl_target = 32'h1002;
    tick();
    chk_state("jmpl_mis", 32'h344, 32'h1000, 0, 1);
    for (int i = 0; i < 5; i++) begin
      advance = 1; br_valid = 1; br_taken = 1; disp = 32'h10;
      tick();
    end
    chk_state("err_hold", 32'h344, 32'h1000, 0, 1);
    trap_to(32'h80);
    chk_state("err_trap", 32'h80, 32'h84, 0, 0);

    // Sequential wrap at the top of the address space
    trap_to(32'hFFFF_FFF8);
    chk_state("trap_top", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0);
    advance = 1;
    tick();
    chk_state("wrap", 32'hFFFF_FFFC, 32'h0, 0, 0);

    // Stall: advance low holds everything
    for (int i = 0; i < 4; i++) begin
      br_valid = 1; br_taken = 1; disp = 32'h40;
      tick();
      chk("stall.pc", pc, 32'hFFFF_FFFC);
      chk("stall.npc", npc, 32'h0);
    end

    // Asynchronous reset mid-cycle from the ANNUL state
    trap_to(32'h500);
    advance = 1; br_valid = 1; br_annul = 1;
    tick();
    chk_state("pre_rst", 32'h504, 32'h508, 1, 0);
    #2;
    reset = 1;
    #1;
    chk_state("async_rst", 32'h0, 32'h4, 0, 0);
    tick();
    reset = 0;
    advance = 1;
    tick();
    chk_state("post_rst", 32'h4, 32'h8, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
